// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply controller: op codes, FSM states and
// helpers that classify an op as signed/unsigned and plain/accumulate/subtract.
package mul_hilo_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned HILO_W = 64;
  localparam int unsigned MRES_W = 66;

  // Last value of cnt in MUL/DRAIN: the array is valid for cnt = 0, 1, 2.
  localparam logic [1:0] CNT_LAST = 2'd2;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MADDU = 3'd3,
    OP_MSUB  = 3'd4,
    OP_MSUBU = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_CORR  = 3'd2,
    ST_WB    = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_e;

  function automatic logic op_is_unsigned(input op_e op);
    return (op == OP_MULTU) || (op == OP_MADDU) || (op == OP_MSUBU);
  endfunction

  function automatic acc_e op_acc(input op_e op);
    acc_e acc;
    case (op)
      OP_MADD, OP_MADDU: acc = ACC_ADD;
      OP_MSUB, OP_MSUBU: acc = ACC_SUB;
      default:           acc = ACC_NONE;
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/mul_hilo_ctrl_if.sv
// EX-stage / multiplier-array bundle seen by the HI/LO multiply controller.
// slave is the controller's view; master is the EX stage / array side.
interface mul_hilo_ctrl_if;
  import mul_hilo_ctrl_pkg::*;

  logic              req_valid;
  logic [2:0]        req_op;
  logic [XLEN-1:0]   src_a;
  logic [XLEN-1:0]   src_b;
  logic              flush;
  logic [HILO_W-1:0] hilo_rdata;
  logic              stall_req;
  logic              mul_valid;
  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic [MRES_W-1:0] mul_result;
  logic              hilo_we;
  logic [HILO_W-1:0] hilo_wdata;
  logic              done;

  modport slave (
    input  req_valid, req_op, src_a, src_b, flush, hilo_rdata, mul_result,
    output stall_req, mul_valid, mul_a, mul_b, hilo_we, hilo_wdata, done
  );

  modport master (
    output req_valid, req_op, src_a, src_b, flush, hilo_rdata, mul_result,
    input  stall_req, mul_valid, mul_a, mul_b, hilo_we, hilo_wdata, done
  );

endinterface

// File: rtl/mul_hilo_ctrl_fix_acc.sv
// Combinational datapath of the multiply controller: turns the signed array
// product into the unsigned one when needed, and forms the HI/LO write value.
module mul_fix_acc
  import mul_hilo_ctrl_pkg::*;
(
  input  op_e               i_op,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  input  logic [HILO_W-1:0] i_prod,
  input  logic [HILO_W-1:0] i_p,
  input  logic [HILO_W-1:0] i_hilo,
  output logic [HILO_W-1:0] o_p_fix,
  output logic [HILO_W-1:0] o_wdata
);

  logic [XLEN-1:0] w_corr;
  logic [XLEN-1:0] w_hi_fix;

  // The array multiplies as signed; an operand with bit 31 set was read as
  // x - 2^32, so adding the other operand into HI restores x * y mod 2^64.
  assign w_corr   = (i_a[XLEN-1] ? i_b : '0) + (i_b[XLEN-1] ? i_a : '0);
  assign w_hi_fix = i_prod[HILO_W-1:XLEN] + w_corr;

  assign o_p_fix = op_is_unsigned(i_op) ? {w_hi_fix, i_prod[XLEN-1:0]} : i_prod;

  // NOTE: every always_comb output gets a value on every path (here via the
  // default arm) so no latch is inferred.
  always_comb begin
    case (op_acc(i_op))
      ACC_ADD: o_wdata = i_hilo + i_p;
      ACC_SUB: o_wdata = i_hilo - i_p;
      default: o_wdata = i_p;
    endcase
  end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// EX-stage controller for the multi-cycle multiplier array: accepts multiply
// class ops, holds operands, stalls the pipe, and emits one HI/LO write.
module mul_hilo_ctrl
  import mul_hilo_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mul_hilo_ctrl_if.slave bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_nxt;
  op_e               r_op;
  logic [XLEN-1:0]   r_mul_a;
  logic [XLEN-1:0]   r_mul_b;
  logic [HILO_W-1:0] r_p;

  logic              w_req_go;
  logic              w_accept;
  logic              w_p_load;
  logic              w_stall;
  logic              w_mul_valid;
  logic              w_hilo_we;
  logic [HILO_W-1:0] w_p_fix;
  logic [HILO_W-1:0] w_wdata;
  logic              w_unused_res_hi;

  assign w_req_go = bus.req_valid & ~bus.flush;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_p_load    = 1'b0;
    w_stall     = 1'b0;
    w_mul_valid = 1'b0;
    w_hilo_we   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_stall = w_req_go;
        if (w_req_go) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_MUL;
        end
      end

      ST_MUL: begin
        w_stall     = 1'b1;
        w_mul_valid = 1'b1;
        w_cnt_nxt   = r_cnt + 2'd1;
        if (r_cnt == CNT_LAST) begin
          // The array has finished its a->b->c walk, so a flush here needs no drain.
          w_cnt_nxt   = '0;
          w_state_nxt = bus.flush ? ST_IDLE : ST_CORR;
        end else if (bus.flush) begin
          w_state_nxt = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        w_stall     = bus.req_valid;
        w_mul_valid = 1'b1;
        w_cnt_nxt   = r_cnt + 2'd1;
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_CORR: begin
        w_stall = 1'b1;
        if (bus.flush) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_p_load    = 1'b1;
          w_state_nxt = ST_WB;
        end
      end

      ST_WB: begin
        w_hilo_we   = ~bus.flush;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operands only load on acceptance; the array re-reads mul_b in its second
  // cycle and CORR still needs both for the unsigned fix-up.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= OP_MULT;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_p     <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= op_e'(bus.req_op);
        r_mul_a <= bus.src_a;
        r_mul_b <= bus.src_b;
      end
      if (w_p_load) begin
        r_p <= w_p_fix;
      end
    end
  end

  mul_fix_acc u_fix_acc (
    .i_op    (r_op),
    .i_a     (r_mul_a),
    .i_b     (r_mul_b),
    .i_prod  (bus.mul_result[HILO_W-1:0]),
    .i_p     (r_p),
    .i_hilo  (bus.hilo_rdata),
    .o_p_fix (w_p_fix),
    .o_wdata (w_wdata)
  );

  // The two guard bits of the array result carry nothing once truncated mod 2^64.
  assign w_unused_res_hi = ^bus.mul_result[MRES_W-1:HILO_W];

  assign bus.stall_req  = w_stall;
  assign bus.mul_valid  = w_mul_valid;
  assign bus.mul_a      = r_mul_a;
  assign bus.mul_b      = r_mul_b;
  assign bus.hilo_we    = w_hilo_we;
  assign bus.done       = w_hilo_we;
  assign bus.hilo_wdata = w_hilo_we ? w_wdata : '0;

endmodule
